// File: rtl/quad_pkg.sv
// Shared types and arithmetic helpers for the quadrature velocity path.
// Pure declarations: no latency, no flow control.
package quad_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_e;

  function automatic int cnt_w(input int ppr);
    return $clog2(ppr * 4 * 2);
  endfunction

  // Shortest signed distance between two counts on a ring of cnt_mod positions.
  function automatic int wrap_delta(input int cur, input int prev, input int cnt_mod);
    int raw;
    raw = cur - prev;
    if (raw >= cnt_mod / 2) begin
      raw = raw - cnt_mod;
    end else if (raw < -(cnt_mod / 2)) begin
      raw = raw + cnt_mod;
    end
    return raw;
  endfunction

endpackage

// File: rtl/moving_avg_pow2.sv
// Boxcar average over 2^AVG_LOG2 samples, floor-rounded; 1-cycle latency from in_valid.
// No backpressure: every in_valid is absorbed; clr empties the window.
module moving_avg_pow2 #(
  parameter int W        = 14,
  parameter int AVG_LOG2 = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                in_valid,
  input  logic signed [W-1:0] in,
  output logic                out_valid,
  output logic signed [W-1:0] out
);

  localparam int N  = 1 << AVG_LOG2;
  localparam int SW = W + AVG_LOG2;

  logic signed [W-1:0]  hist_q [N];
  logic signed [SW-1:0] sum_q;
  logic signed [SW-1:0] sum_d;
  logic signed [W-1:0]  out_q;
  logic                 out_valid_q;

  assign sum_d = sum_q + SW'(in) - SW'(hist_q[N-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) hist_q[i] <= '0;
      sum_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (clr) begin
        for (int i = 0; i < N; i++) hist_q[i] <= '0;
        sum_q <= '0;
      end else if (in_valid) begin
        hist_q[0] <= in;
        for (int i = 1; i < N; i++) hist_q[i] <= hist_q[i-1];
        sum_q       <= sum_d;
        // Arithmetic shift floors toward minus infinity.
        out_q       <= W'(sum_d >>> AVG_LOG2);
        out_valid_q <= 1'b1;
      end
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: rtl/quadrature_velocity.sv
// Windowed velocity/direction/stall estimate from a wrapping position count.
// Outputs update one cycle after the window's terminal sample; no backpressure, en=0 aborts.
module quadrature_velocity
  import quad_pkg::*;
#(
  parameter int PPR           = 960,
  parameter int CNT_MOD       = PPR * 4 * 2,
  parameter int SAMPLE_CYCLES = 12,
  parameter int AVG_LOG2      = 2,
  parameter int STALL_WINDOWS = 4,
  localparam int CW           = cnt_w(PPR)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [CW-1:0]        p_cnt,
  output logic signed [CW:0]   vel,
  output logic                 vel_valid,
  output logic                 dir,
  output logic                 stalled
);

  localparam int TW = $clog2(SAMPLE_CYCLES);
  localparam int ZW = $clog2(STALL_WINDOWS + 1);
  localparam logic [TW-1:0] TC_VAL = TW'(SAMPLE_CYCLES - 1);
  localparam logic [ZW-1:0] Z_SAT  = ZW'(STALL_WINDOWS);

  state_e             state_q;
  logic [TW-1:0]      win_q;
  logic [CW-1:0]      prev_q;
  logic [CW-1:0]      cur_q;
  logic               pend_q;
  logic [ZW-1:0]      zrun_q;
  logic [ZW-1:0]      zrun_d;
  logic               stalled_q;
  logic signed [CW:0] delta_d;
  logic               tc;
  logic               strobe_in;
  logic               clr;

  assign tc        = (win_q == TC_VAL);
  assign strobe_in = pend_q & en;
  assign clr       = en & (state_q == IDLE);
  assign delta_d   = (CW+1)'(wrap_delta(int'(cur_q), int'(prev_q), CNT_MOD));

  always_comb begin
    zrun_d = zrun_q;
    if (delta_d != '0) begin
      zrun_d = '0;
    end else if (zrun_q != Z_SAT) begin
      zrun_d = zrun_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= '0;
      prev_q  <= '0;
      cur_q   <= '0;
      pend_q  <= 1'b0;
    end else if (!en) begin
      // Abort the window; a sample captured on this edge is dropped.
      state_q <= IDLE;
      win_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      pend_q <= 1'b0;
      win_q  <= tc ? '0 : win_q + 1'b1;
      if (pend_q) prev_q <= cur_q;
      case (state_q)
        IDLE: begin
          state_q <= PRIME;
          win_q   <= '0;
        end
        PRIME: if (tc) begin
          prev_q  <= p_cnt;
          state_q <= RUN;
        end
        RUN: if (tc) begin
          cur_q  <= p_cnt;
          pend_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zrun_q    <= '0;
      stalled_q <= 1'b0;
    end else if (strobe_in) begin
      zrun_q    <= zrun_d;
      stalled_q <= (zrun_d == Z_SAT);
    end
  end

  moving_avg_pow2 #(
    .W        (CW + 1),
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (strobe_in),
    .in        (delta_d),
    .out_valid (vel_valid),
    .out       (vel)
  );

  assign dir     = ~vel[CW];
  assign stalled = stalled_q;

endmodule
